// File: rtl/fetch_stage_pkg.sv
// Shared types, defaults and helpers for the fetch stage.
// Provides INST_PACKET, the FETCH_STATE enum and the INST_BUFF_DEPTH / FETCH_WIDTH defaults.
`ifndef INST_BUFF_DEPTH
`define INST_BUFF_DEPTH 16
`endif
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package fetch_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
    } INST_PACKET;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } FETCH_STATE;

    // Build a freshly fetched packet; every field not named here stays zero.
    function automatic INST_PACKET make_packet(input logic [31:0] inst, input logic [31:0] pc);
        INST_PACKET p;
        p       = '0;
        p.valid = 1'b1;
        p.inst  = inst;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        return p;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_staging_fifo.sv
// Circular staging FIFO between the I-cache response and the instruction buffer.
// Push 0-2 packets and pop 0-POP_MAX packets per cycle; flush empties it.
module fetch_staging_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int POP_MAX = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             push_cnt,
    input  INST_PACKET [1:0]       push_pkt,
    input  logic [2:0]             pop_cnt,
    output logic [CNT_W-1:0]       count,
    output INST_PACKET [POP_MAX-1:0] peek
);

    INST_PACKET        mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;

    // Pointer advance modulo DEPTH (works for non power-of-two depths too).
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input int unsigned n);
        int unsigned sum_v;
        sum_v = (32'(ptr) + n) % 32'(DEPTH);
        return PTR_W'(sum_v);
    endfunction

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_r[tail_r] <= push_pkt[0];
            end
            if (push_cnt == 2'd2) begin
                mem_r[wrap_add(tail_r, 32'd1)] <= push_pkt[1];
            end
            head_r  <= wrap_add(head_r, 32'(pop_cnt));
            tail_r  <= wrap_add(tail_r, 32'(push_cnt));
            count_r <= count_r - CNT_W'(pop_cnt) + CNT_W'(push_cnt);
        end
    end

    // Oldest-first view of the entries starting at head.
    always_comb begin
        peek = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            peek[i] = mem_r[wrap_add(head_r, i)];
        end
    end

    assign count = count_r;

    fetch_staging_fifo_checker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_checker (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .count    (count_r),
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt)
    );

endmodule

// File: rtl/fetch_staging_fifo_checker.sv
// Occupancy invariants of the fetch staging FIFO (simulation-only checks).
module fetch_staging_fifo_checker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
)(
    input logic             clock,
    input logic             reset,
    input logic             flush,
    input logic [CNT_W-1:0] count,
    input logic [1:0]       push_cnt,
    input logic [2:0]       pop_cnt
);

    // Never pop more than is held, never push past capacity.
    pop_within_count: assert property (@(posedge clock) disable iff (!reset)
        flush || (int'(pop_cnt) <= int'(count)));

    no_overflow: assert property (@(posedge clock) disable iff (!reset)
        flush || ((int'(count) - int'(pop_cnt) + int'(push_cnt)) <= DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, one-outstanding I-cache block request, staging FIFO and
// width-limited hand-off to the instruction buffer, with branch squash.
// Optional feature macro: FETCH_PERF_EN adds saturating perf counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          FETCH_WIDTH = `FETCH_WIDTH,
    parameter int          STAGE_DEPTH = 4,
    parameter int          BUFF_DEPTH  = `INST_BUFF_DEPTH,
    parameter logic [31:0] RESET_PC    = 32'h0,
    localparam int         OE_W        = $clog2(BUFF_DEPTH + 1),
    localparam int         CNT_W       = $clog2(STAGE_DEPTH + 1)
)(
    input  logic                        clock,
    input  logic                        reset,
    input  logic [OE_W-1:0]             open_entries,
    input  logic                        br_en,
    input  logic [31:0]                 br_target_pc,
    output logic                        icache_req_valid,
    output logic [31:0]                 icache_req_addr,
    input  logic                        icache_req_ready,
    input  logic                        icache_resp_valid,
    input  logic [63:0]                 icache_resp_data,
    output INST_PACKET [FETCH_WIDTH-1:0] out_insts,
    output logic [2:0]                  num_accept
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                 perf_fetched,
    output logic [31:0]                 perf_wait_cycles,
    output logic [31:0]                 perf_dropped
`endif
);

    FETCH_STATE                  state_r;
    FETCH_STATE                  state_next_s;
    logic [31:0]                 pc_r;
    logic [31:0]                 block_base_s;
    logic [CNT_W-1:0]            count_s;
    logic [CNT_W-1:0]            occ_after_s;
    logic                        req_valid_s;
    logic [1:0]                  push_cnt_s;
    INST_PACKET [1:0]            push_pkt_s;
    INST_PACKET [FETCH_WIDTH-1:0] peek_s;
    int                          avail_s;

    assign block_base_s    = {pc_r[31:3], 3'b000};
    assign icache_req_addr = block_base_s;

    // Drain count: bounded by staged entries, buffer space and port width; zero on squash.
    always_comb begin
        avail_s = int'(count_s);
        if (int'(open_entries) < avail_s) begin
            avail_s = int'(open_entries);
        end else begin
            avail_s = avail_s;
        end
        if (FETCH_WIDTH < avail_s) begin
            avail_s = FETCH_WIDTH;
        end else begin
            avail_s = avail_s;
        end
        if (br_en) begin
            num_accept = 3'd0;
        end else begin
            num_accept = 3'(avail_s);
        end
    end

    // Present the oldest num_accept entries, zero the rest.
    always_comb begin
        out_insts = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (i < int'(num_accept)) begin
                out_insts[i] = peek_s[i];
            end else begin
                out_insts[i] = '0;
            end
        end
    end

    // Issue only when the staging FIFO can absorb a full 2-instruction block.
    always_comb begin
        occ_after_s = count_s - CNT_W'(num_accept);
        if (reset && (state_r == IDLE) && !br_en && (occ_after_s <= CNT_W'(STAGE_DEPTH - 2))) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    assign icache_req_valid = req_valid_s;

    // Unpack a live response; an odd-word PC keeps only the upper instruction.
    always_comb begin
        push_cnt_s = 2'd0;
        push_pkt_s = '0;
        if ((state_r == WAIT) && icache_resp_valid && !br_en) begin
            if (!pc_r[2]) begin
                push_cnt_s    = 2'd2;
                push_pkt_s[0] = make_packet(icache_resp_data[31:0],  block_base_s);
                push_pkt_s[1] = make_packet(icache_resp_data[63:32], block_base_s + 32'd4);
            end else begin
                push_cnt_s    = 2'd1;
                push_pkt_s[0] = make_packet(icache_resp_data[63:32], block_base_s + 32'd4);
            end
        end else begin
            push_cnt_s = 2'd0;
        end
    end

    // Next-state logic; a squash during WAIT turns the pending response into a drop.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!br_en && req_valid_s && icache_req_ready) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (icache_resp_valid) begin
                    state_next_s = IDLE;
                end else if (br_en) begin
                    state_next_s = DROP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            DROP: begin
                if (icache_resp_valid) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DROP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC: redirect on squash, otherwise advance one block per consumed response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else if (br_en) begin
            pc_r <= br_target_pc;
        end else if ((state_r == WAIT) && icache_resp_valid) begin
            pc_r <= block_base_s + 32'd8;
        end else begin
            pc_r <= pc_r;
        end
    end

    fetch_staging_fifo #(
        .DEPTH   (STAGE_DEPTH),
        .POP_MAX (FETCH_WIDTH)
    ) u_staging (
        .clock    (clock),
        .reset    (reset),
        .flush    (br_en),
        .push_cnt (push_cnt_s),
        .push_pkt (push_pkt_s),
        .pop_cnt  (num_accept),
        .count    (count_s),
        .peek     (peek_s)
    );

`ifdef FETCH_PERF_EN
    logic dropped_event_s;
    assign dropped_event_s = icache_resp_valid &&
                             ((state_r == DROP) || ((state_r == WAIT) && br_en));

    // Saturating throughput / stall / drop counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched     <= 32'd0;
            perf_wait_cycles <= 32'd0;
            perf_dropped     <= 32'd0;
        end else begin
            perf_fetched     <= sat_add32(perf_fetched, 32'(num_accept));
            perf_wait_cycles <= sat_add32(perf_wait_cycles,
                                          ((state_r == WAIT) || (state_r == DROP)) ? 32'd1 : 32'd0);
            perf_dropped     <= sat_add32(perf_dropped, dropped_event_s ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model checked every
// cycle on the falling edge, plus hand-computed literal checks per scenario.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int FW = 4;
    localparam int SD = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [4:0]          open_entries;
    logic                br_en;
    logic [31:0]         br_target_pc;
    logic                icache_req_valid;
    logic [31:0]         icache_req_addr;
    logic                icache_req_ready;
    logic                icache_resp_valid;
    logic [63:0]         icache_resp_data;
    INST_PACKET [FW-1:0] out_insts;
    logic [2:0]          num_accept;
`ifdef FETCH_PERF_EN
    logic [31:0]         perf_fetched;
    logic [31:0]         perf_wait_cycles;
    logic [31:0]         perf_dropped;
`endif

    int nvec  = 0;
    int nfail = 0;

    // Reference model state.
    INST_PACKET  mq[$];
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_base = 32'h0;
    bit          m_out  = 1'b0;
    bit          m_doom = 1'b0;
    logic [31:0] m_fetched = 32'd0;
    logic [31:0] m_waits   = 32'd0;
    logic [31:0] m_drops   = 32'd0;

    always #5 clock = ~clock;

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .open_entries      (open_entries),
        .br_en             (br_en),
        .br_target_pc      (br_target_pc),
        .icache_req_valid  (icache_req_valid),
        .icache_req_addr   (icache_req_addr),
        .icache_req_ready  (icache_req_ready),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_data  (icache_resp_data),
        .out_insts         (out_insts),
        .num_accept        (num_accept)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_wait_cycles  (perf_wait_cycles),
        .perf_dropped      (perf_dropped)
`endif
    );

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return (a << 8) | 32'h13;
    endfunction

    function automatic INST_PACKET pkt(input logic [31:0] inst, input logic [31:0] pc);
        INST_PACKET p;
        p       = '0;
        p.inst  = inst;
        p.PC    = pc;
        p.NPC   = pc + 32'd4;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model.
    always @(negedge clock) begin
        int          na;
        bit          rv_e;
        INST_PACKET  exp_p;
        logic [31:0] base;
        if (!reset) begin
            chk("rst_req_valid", icache_req_valid, 1'b0);
            chk("rst_num_accept", num_accept, 3'd0);
            chk("rst_out_insts", out_insts, '0);
            mq.delete();
            m_pc = 32'h0; m_out = 1'b0; m_doom = 1'b0;
            m_fetched = 32'd0; m_waits = 32'd0; m_drops = 32'd0;
`ifdef FETCH_PERF_EN
            chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        end else begin
            na = mq.size();
            if (int'(open_entries) < na) na = int'(open_entries);
            if (na > FW) na = FW;
            if (br_en) na = 0;
            rv_e = !br_en && !m_out && ((mq.size() - na) <= SD - 2);
            chk("num_accept", num_accept, na);
            for (int i = 0; i < FW; i++) begin
                exp_p = (i < na) ? mq[i] : '0;
                chk("out_insts", out_insts[i], exp_p);
            end
            chk("req_valid", icache_req_valid, rv_e);
            base = {m_pc[31:3], 3'b000};
            if (rv_e) chk("req_addr", icache_req_addr, base);
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_wait_cycles", perf_wait_cycles, m_waits);
            chk("perf_dropped", perf_dropped, m_drops);
`endif
            m_fetched = m_fetched + 32'(na);
            if (m_out) m_waits = m_waits + 32'd1;
            if (br_en) begin
                mq.delete();
                if (m_out) begin
                    if (icache_resp_valid) begin
                        m_out = 1'b0; m_doom = 1'b0; m_drops = m_drops + 32'd1;
                    end else begin
                        m_doom = 1'b1;
                    end
                end
                m_pc = br_target_pc;
            end else begin
                repeat (na) void'(mq.pop_front());
                if (m_out && icache_resp_valid) begin
                    if (m_doom) begin
                        m_drops = m_drops + 32'd1;
                    end else begin
                        if (!m_pc[2]) mq.push_back(pkt(icache_resp_data[31:0], base));
                        mq.push_back(pkt(icache_resp_data[63:32], base + 32'd4));
                        m_pc = base + 32'd8;
                    end
                    m_out = 1'b0; m_doom = 1'b0;
                end else if (rv_e && icache_req_ready) begin
                    m_out = 1'b1; m_base = base;
                end
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge; response data follows the outstanding block.
    task automatic cyc(input int oe, input bit br, input logic [31:0] tgt, input bit rdy, input bit rv);
        @(posedge clock);
        #1;
        open_entries      = 5'(oe);
        br_en             = br;
        br_target_pc      = tgt;
        icache_req_ready  = rdy;
        icache_resp_valid = rv;
        icache_resp_data  = {f_inst(m_base + 32'd4), f_inst(m_base)};
        #1;
    endtask

    initial begin
        open_entries = 5'd16; br_en = 1'b0; br_target_pc = 32'h0;
        icache_req_ready = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = 64'h0;
        repeat (3) @(posedge clock);
        #2;
        chk("lit_reset_req_valid", icache_req_valid, 1'b0);
        chk("lit_reset_num_accept", num_accept, 3'd0);
        @(posedge clock); #1 reset = 1'b1;

        // Reset fetch
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t1_req_valid", icache_req_valid, 1'b1);
        chk("lit_t1_addr0", icache_req_addr, 32'h0);
        cyc(16, 0, 32'h0, 0, 1);
        chk("lit_t1_wait_no_req", icache_req_valid, 1'b0);
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t1_na", num_accept, 3'd2);
        chk("lit_t1_pc0", out_insts[0].PC, 32'h0);
        chk("lit_t1_pc1", out_insts[1].PC, 32'h4);
        chk("lit_t1_inst0", out_insts[0].inst, 32'h0000_0013);
        chk("lit_t1_addr8", icache_req_addr, 32'h8);
        cyc(16, 0, 32'h0, 0, 1);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t1_pc8", out_insts[0].PC, 32'h8);
        chk("lit_t1_addr10", icache_req_addr, 32'h10);

        // Unaligned start
        cyc(16, 1, 32'h14, 0, 0);
        chk("lit_t2_br_no_req", icache_req_valid, 1'b0);
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t2_addr10", icache_req_addr, 32'h10);
        cyc(16, 0, 32'h0, 0, 1);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t2_na", num_accept, 3'd1);
        chk("lit_t2_pc14", out_insts[0].PC, 32'h14);
        chk("lit_t2_npc18", out_insts[0].NPC, 32'h18);
        chk("lit_t2_slot1_zero", out_insts[1], '0);
        chk("lit_t2_addr18", icache_req_addr, 32'h18);

        // Backpressure
        cyc(0, 0, 32'h0, 1, 0);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 1, 0);
        chk("lit_t3_req_at_2", icache_req_valid, 1'b1);
        chk("lit_t3_addr20", icache_req_addr, 32'h20);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 1, 0);
        chk("lit_t3_full_no_req", icache_req_valid, 1'b0);
        chk("lit_t3_full_na", num_accept, 3'd0);
        cyc(0, 0, 32'h0, 1, 0);
        chk("lit_t3_hold_na", num_accept, 3'd0);
        cyc(3, 0, 32'h0, 0, 0);
        chk("lit_t3_na3", num_accept, 3'd3);
        chk("lit_t3_oldest", out_insts[0].PC, 32'h18);
        chk("lit_t3_third", out_insts[2].PC, 32'h20);
        chk("lit_t3_slot3_zero", out_insts[3], '0);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t3_last", out_insts[0].PC, 32'h24);

        // Squash while waiting
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t4_addr28", icache_req_addr, 32'h28);
        cyc(16, 1, 32'h100, 0, 0);
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t4_drop_no_req", icache_req_valid, 1'b0);
        cyc(16, 0, 32'h0, 0, 1);
        cyc(16, 0, 32'h0, 1, 0);
        chk("lit_t4_na0", num_accept, 3'd0);
        chk("lit_t4_addr100", icache_req_addr, 32'h100);
`ifdef FETCH_PERF_EN
        chk("lit_t4_perf_dropped", perf_dropped, 32'd1);
`endif
        cyc(16, 0, 32'h0, 0, 1);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t4_pc100", out_insts[0].PC, 32'h100);

        // Squash and response in the same cycle
        cyc(16, 0, 32'h0, 1, 0);
        cyc(16, 1, 32'h200, 0, 1);
        chk("lit_t5_br_na", num_accept, 3'd0);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t5_na0", num_accept, 3'd0);
        chk("lit_t5_addr200", icache_req_addr, 32'h200);
        chk("lit_t5_req", icache_req_valid, 1'b1);
`ifdef FETCH_PERF_EN
        chk("lit_t5_perf_dropped", perf_dropped, 32'd2);
`endif

        // Asynchronous reset while a request is outstanding
        cyc(0, 0, 32'h0, 1, 0);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 1, 0);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t6_pre_na", num_accept, 3'd2);
        #1 reset = 1'b0;
        #1;
        chk("lit_t6_async_na", num_accept, 3'd0);
        chk("lit_t6_async_out", out_insts, '0);
        chk("lit_t6_async_req", icache_req_valid, 1'b0);
        cyc(16, 0, 32'h0, 0, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        icache_req_ready  = 1'b0;
        icache_resp_valid = 1'b1;
        #1;
        chk("lit_t6_req_after", icache_req_valid, 1'b1);
        chk("lit_t6_addr_reset_pc", icache_req_addr, 32'h0);
        cyc(16, 0, 32'h0, 0, 0);
        chk("lit_t6_late_ignored", num_accept, 3'd0);
        cyc(16, 0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
